// File: rtl/riscv_periph_pkg.sv
// Shared definitions for the RISC-V peripheral register blocks.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package riscv_periph_pkg;

  // Register offsets, selected by daddr[3:2]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_RSVD    = 2'd3;

  // STATUS write bit that clears the sticky overflow flag
  localparam int ST_OVF_BIT = 3;

  // Shortest legal bit period in core clocks
  localparam logic [15:0] BIT_PERIOD_MIN = 16'd2;

  // Transmitter FSM state encoding
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // STATUS register layout, LSB first: full, empty, busy, overflow, count
  typedef struct packed {
    logic [22:0] rsvd;
    logic [4:0]  count;
    logic        overflow;
    logic        busy;
    logic        empty;
    logic        full;
  } status_t;

  // Bit period actually used for a BAUDDIV value (clamped to the minimum)
  function automatic logic [15:0] eff_period(input logic [15:0] div);
    return (div < BIT_PERIOD_MIN) ? BIT_PERIOD_MIN : div;
  endfunction

endpackage

// File: rtl/riscv_sync_fifo.sv
// Single-clock FIFO with separate occupancy counter and wrapping pointers.
// Latency: a push is visible at the head one cycle later; head data is combinational.
// Backpressure: push_rdy low when full unless a pop happens in the same cycle.
module riscv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  output logic                       push_rdy,
  input  logic                       pop_vld,
  output logic [WIDTH-1:0]           pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign do_pop   = pop_vld & ~empty;
  assign push_rdy = ~full | do_pop;
  assign do_push  = push_vld & push_rdy;
  assign pop_dat  = mem[rd_ptr];

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/riscv_uart_tx.sv
// Memory-mapped UART transmitter: TX FIFO, 8N1 serialiser, STATUS/BAUDDIV registers.
// Latency: register reads return one cycle after drd_i; a queued byte starts its frame the next cycle.
// Backpressure: none on the bus; writes to a full FIFO are dropped and flag overflow.
module riscv_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] daddr_i,
  input  logic [31:0] dwdata_i,
  input  logic [1:0]  dsize_i,
  input  logic        drd_i,
  input  logic        dwr_i,
  output logic [31:0] drdata_o,
  output logic        tx_o,
  output logic        irq_o
);

  import riscv_periph_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Bus decode
  logic        sel;
  logic        rd_hit;
  logic        wr_hit;
  logic [1:0]  reg_off;
  logic        ovf_clr;
  logic        div_wr;
  logic        unused_bits;

  // FIFO interface
  logic             push_vld;
  logic             push_rdy;
  logic             pop_vld;
  logic [7:0]       pop_dat;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Registers
  logic        ovf_q;
  logic [15:0] bauddiv_q;
  logic        irq_q;
  status_t     status;
  logic [31:0] rd_val;

  // Serialiser
  tx_state_e   state_q;
  tx_state_e   state_d;
  logic [15:0] period_q;
  logic [15:0] baud_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shreg_q;
  logic        bit_end;
  logic        load;
  logic        busy;
  logic        tx_bit;

  // Access size and byte-lane address bits play no part in decode
  assign unused_bits = ^{dsize_i, daddr_i[1:0], dwdata_i[31:16]};

  assign sel      = (daddr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_off  = daddr_i[3:2];
  assign rd_hit   = drd_i & sel;
  assign wr_hit   = dwr_i & sel;
  assign push_vld = wr_hit & (reg_off == REG_TXDATA);
  assign ovf_clr  = wr_hit & (reg_off == REG_STATUS) & dwdata_i[ST_OVF_BIT];
  assign div_wr   = wr_hit & (reg_off == REG_BAUDDIV);

  riscv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (reset_i),
    .push_vld (push_vld),
    .push_dat (dwdata_i[7:0]),
    .push_rdy (push_rdy),
    .pop_vld  (pop_vld),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Last cycle of the current bit slot
  assign bit_end = (baud_cnt_q == period_q - 16'd1);

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: STOP chains straight into START when more data is queued
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (!fifo_empty) state_d = TX_START;
      TX_START: if (bit_end) state_d = TX_DATA;
      TX_DATA:  if (bit_end && (bit_idx_q == 3'd7)) state_d = TX_STOP;
      TX_STOP:  if (bit_end) state_d = fifo_empty ? TX_IDLE : TX_START;
      default:  state_d = TX_IDLE;
    endcase
  end

  // FSM outputs: line level, busy flag and FIFO pop on every START entry
  always_comb begin
    load   = 1'b0;
    busy   = 1'b1;
    tx_bit = 1'b1;
    case (state_q)
      TX_IDLE: begin
        busy = 1'b0;
        load = ~fifo_empty;
      end
      TX_START: tx_bit = 1'b0;
      TX_DATA:  tx_bit = shreg_q[0];
      TX_STOP:  load = bit_end & ~fifo_empty;
      default: ;
    endcase
  end

  assign pop_vld = load;
  assign tx_o    = tx_bit;

  // Shift register and bit timing; the period is frozen for the whole frame at START entry
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shreg_q    <= '0;
      period_q   <= BIT_PERIOD_MIN;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
    end else if (load) begin
      shreg_q    <= pop_dat;
      period_q   <= eff_period(bauddiv_q);
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
    end else if (busy) begin
      if (bit_end) begin
        baud_cnt_q <= '0;
        if (state_q == TX_DATA) begin
          shreg_q   <= {1'b0, shreg_q[7:1]};
          bit_idx_q <= bit_idx_q + 3'd1;
        end
      end else begin
        baud_cnt_q <= baud_cnt_q + 16'd1;
      end
    end
  end

  // Sticky overflow: set by a dropped push, cleared by software
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ovf_q <= 1'b0;
    end else if (push_vld && !push_rdy) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  // Baud divisor register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bauddiv_q <= DIV_RESET;
    end else if (div_wr) begin
      bauddiv_q <= dwdata_i[15:0];
    end
  end

  // Interrupt: nothing left to send and the line has gone idle
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      irq_q <= 1'b1;
    end else begin
      irq_q <= fifo_empty & ~busy;
    end
  end

  assign irq_o = irq_q;

  // STATUS image and read mux
  always_comb begin
    status          = '0;
    status.count    = 5'(fifo_count);
    status.overflow = ovf_q;
    status.busy     = busy;
    status.empty    = fifo_empty;
    status.full     = fifo_full;
    rd_val          = '0;
    case (reg_off)
      REG_STATUS:  rd_val = status;
      REG_BAUDDIV: rd_val = {16'h0000, bauddiv_q};
      default:     rd_val = '0;
    endcase
  end

  // Read data is held for exactly one cycle after a selected read, zero otherwise
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drdata_o <= '0;
    end else if (rd_hit) begin
      drdata_o <= rd_val;
    end else begin
      drdata_o <= '0;
    end
  end

endmodule

// File: tb/tb_riscv_uart_tx.sv
// Self-checking bench for riscv_uart_tx: register vectors, frame vectors, corner sequences.
// Inputs change 2 time units after posedge; outputs are sampled on negedge.
// A line monitor decodes frames and checks them against a scoreboard queue.
module tb_riscv_uart_tx;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] daddr_i;
  logic [31:0] dwdata_i;
  logic [1:0]  dsize_i;
  logic        drd_i;
  logic        dwr_i;
  logic [31:0] drdata_o;
  logic        tx_o;
  logic        irq_o;

  always #5 clk_i = ~clk_i;

  riscv_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8),
    .DIV_RESET  (16'd16)
  ) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .daddr_i  (daddr_i),
    .dwdata_i (dwdata_i),
    .dsize_i  (dsize_i),
    .drd_i    (drd_i),
    .dwr_i    (dwr_i),
    .drdata_o (drdata_o),
    .tx_o     (tx_o),
    .irq_o    (irq_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cur_div = 16;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_period(input logic [15:0] d);
    return (d < 16'd2) ? 2 : int'(d);
  endfunction

  // Scoreboard of frames expected on the line
  typedef struct {
    logic [7:0] data;
    int         period;
  } frame_t;

  frame_t exp_q[$];
  int     start_q[$];
  int     end_q[$];

  // Line monitor
  logic       mon_active = 1'b0;
  int         mon_cnt;
  int         mon_err;
  int         mon_seg;
  int         mon_ph;
  logic       mon_lvl;
  logic [7:0] mon_rx;
  frame_t     mon_exp;

  always @(negedge clk_i) begin
    cyc++;
    if (reset_i) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && tx_o == 1'b0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: start bit at cycle %0d with nothing queued", cyc);
          mon_exp.data   = 8'h00;
          mon_exp.period = exp_period(16'(cur_div));
        end else begin
          mon_exp = exp_q.pop_front();
        end
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_err    = 0;
        mon_rx     = 8'h00;
        start_q.push_back(cyc);
      end
      if (mon_active) begin
        mon_seg = mon_cnt / mon_exp.period;
        mon_ph  = mon_cnt % mon_exp.period;
        mon_lvl = (mon_seg == 0) ? 1'b0 : (mon_seg <= 8) ? mon_exp.data[mon_seg-1] : 1'b1;
        if (tx_o !== mon_lvl) mon_err++;
        if (mon_seg >= 1 && mon_seg <= 8 && mon_ph == mon_exp.period / 2) mon_rx[mon_seg-1] = tx_o;
        mon_cnt++;
        if (mon_cnt == 10 * mon_exp.period) begin
          check("frame_data", {24'h0, mon_rx}, {24'h0, mon_exp.data});
          check("frame_shape_errs", mon_err, 0);
          end_q.push_back(cyc);
          mon_active = 1'b0;
        end
      end
    end
  end

  // Bus helpers: every task is entered and left 2 units after a posedge
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    daddr_i  = a;
    dwdata_i = d;
    dsize_i  = 2'($urandom_range(0, 3));
    dwr_i    = 1'b1;
    drd_i    = 1'b0;
    @(posedge clk_i);
    #2;
    dwr_i = 1'b0;
  endtask

  task automatic tx_byte(input logic [7:0] b, input int period);
    frame_t f;
    f.data   = b;
    f.period = period;
    exp_q.push_back(f);
    bus_write(BASE, {24'h0, b});
  endtask

  task automatic set_div(input logic [15:0] d);
    bus_write(BASE + 32'h8, {16'h0, d});
    cur_div = int'(d);
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name, input bit timing);
    daddr_i = a;
    dsize_i = 2'($urandom_range(0, 3));
    drd_i   = 1'b1;
    dwr_i   = 1'b0;
    if (timing) begin
      @(negedge clk_i);
      check({name, "_before"}, drdata_o, 32'h0);
    end
    @(posedge clk_i);
    #2;
    drd_i = 1'b0;
    @(negedge clk_i);
    check(name, drdata_o, exp);
    @(posedge clk_i);
    #2;
    if (timing) begin
      @(negedge clk_i);
      check({name, "_after"}, drdata_o, 32'h0);
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < limit) begin
      @(posedge clk_i);
      #2;
      n++;
    end
    check({name, "_drain_timeout"}, (n >= limit) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic check_line(input string name, input logic exp_irq);
    @(negedge clk_i);
    check({name, "_irq"}, {31'h0, irq_o}, {31'h0, exp_irq});
    check({name, "_tx"}, {31'h0, tx_o}, 32'h1);
    @(posedge clk_i);
    #2;
  endtask

  // Stimulus tables
  typedef struct {
    logic [31:0] waddr;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] rexp;
    string       name;
  } regvec_t;

  typedef struct {
    logic [15:0] div;
    logic [7:0]  data;
  } framevec_t;

  regvec_t   rv[8];
  framevec_t fv[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;

    rv[0] = '{BASE,         1'b0, 32'h0,         BASE + 32'h4,  32'h0000_0002, "status_reset"};
    rv[1] = '{BASE,         1'b0, 32'h0,         BASE + 32'h8,  32'h0000_0010, "div_reset"};
    rv[2] = '{BASE + 32'h8, 1'b1, 32'hDEAD_0007, BASE + 32'h8,  32'h0000_0007, "div_rw"};
    rv[3] = '{BASE + 32'hC, 1'b1, 32'hFFFF_FFFF, BASE + 32'hC,  32'h0,         "rsvd_rw"};
    rv[4] = '{BASE,         1'b0, 32'h0,         BASE,          32'h0,         "txdata_read"};
    rv[5] = '{BASE + 32'h4, 1'b1, 32'hFFFF_FFFF, BASE + 32'h4,  32'h0000_0002, "status_ro"};
    rv[6] = '{32'h9000_0008,1'b1, 32'h0000_0055, BASE + 32'h8,  32'h0000_0007, "foreign_write"};
    rv[7] = '{BASE + 32'h8, 1'b1, 32'h0001_0010, BASE + 32'h8,  32'h0000_0010, "div_restore"};

    fv[0] = '{16'd4, 8'h55};
    fv[1] = '{16'd2, 8'hA3};
    fv[2] = '{16'd0, 8'h0F};
    fv[3] = '{16'd1, 8'hF0};
    fv[4] = '{16'd3, 8'h81};
    fv[5] = '{16'd5, 8'h00};
    fv[6] = '{16'd2, 8'hFF};

    reset_i  = 1'b1;
    daddr_i  = 32'h0;
    dwdata_i = 32'h0;
    dsize_i  = 2'd0;
    drd_i    = 1'b0;
    dwr_i    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_tx", {31'h0, tx_o}, 32'h1);
    check("rst_irq", {31'h0, irq_o}, 32'h1);
    check("rst_drdata", drdata_o, 32'h0);
    @(posedge clk_i);
    #2;
    reset_i = 1'b0;
    check_line("after_release", 1'b1);

    // Register vectors
    for (int i = 0; i < 8; i++) begin
      if (rv[i].wr) bus_write(rv[i].waddr, rv[i].wdata);
      bus_read(rv[i].raddr, rv[i].rexp, rv[i].name, 1'b0);
    end
    cur_div = 16;

    // Frame vectors, including the clamp of BAUDDIV 0 and 1 to two cycles
    for (int i = 0; i < 7; i++) begin
      set_div(fv[i].div);
      tx_byte(fv[i].data, exp_period(fv[i].div));
      drain($sformatf("frame%0d", i), 400);
      idle(2);
      check_line($sformatf("frame%0d_done", i), 1'b1);
      bus_read(BASE + 32'h4, 32'h0000_0002, $sformatf("frame%0d_status", i), 1'b0);
    end

    // Overflow: nine writes while the first frame is in its start bit
    set_div(16'd16);
    tx_byte(8'h11, 16);
    idle(1);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_byte(8'(8'h20 + i), 16);
      else bus_write(BASE, 32'h0000_0099);
    end
    bus_read(BASE + 32'h4, 32'h0000_008D, "ovf_status", 1'b0);
    bus_write(BASE + 32'h4, 32'h0000_0007);
    bus_read(BASE + 32'h4, 32'h0000_008D, "ovf_sticky", 1'b0);
    bus_write(BASE + 32'h4, 32'h0000_0008);
    bus_read(BASE + 32'h4, 32'h0000_0085, "ovf_clear", 1'b0);
    drain("burst", 2000);

    // Read latency and address decode
    bus_read(BASE + 32'h4, 32'h0000_0002, "status_timing", 1'b1);
    bus_read(32'h9000_0004, 32'h0, "foreign_read", 1'b1);

    // Back-to-back frames at the minimum period
    set_div(16'd2);
    start_q.delete();
    end_q.delete();
    tx_byte(8'h3C, 2);
    tx_byte(8'hC3, 2);
    drain("b2b", 200);
    check("b2b_starts", start_q.size(), 2);
    check("b2b_ends", end_q.size(), 2);
    if (start_q.size() == 2 && end_q.size() == 2) begin
      check("b2b_gap", start_q[1] - end_q[0], 1);
      check("b2b_span", end_q[1] - start_q[0] + 1, 40);
    end

    // BAUDDIV change mid-frame only affects the following frame
    set_div(16'd4);
    tx_byte(8'h5A, 4);
    tx_byte(8'hA5, 8);
    idle(8);
    @(negedge clk_i);
    check("midframe_irq", {31'h0, irq_o}, 32'h0);
    @(posedge clk_i);
    #2;
    set_div(16'd8);
    drain("div_change", 300);
    bus_read(BASE + 32'h8, 32'h0000_0008, "div_change_rd", 1'b0);

    // Reset in the middle of a frame with another byte still queued
    tx_byte(8'h77, 8);
    tx_byte(8'h88, 8);
    idle(30);
    reset_i = 1'b1;
    exp_q.delete();
    @(negedge clk_i);
    check("abort_tx", {31'h0, tx_o}, 32'h1);
    check("abort_irq", {31'h0, irq_o}, 32'h1);
    @(posedge clk_i);
    #2;
    idle(1);
    reset_i = 1'b0;
    cur_div = 16;
    idle(1);
    bus_read(BASE + 32'h4, 32'h0000_0002, "abort_status", 1'b0);
    bus_read(BASE + 32'h8, 32'h0000_0010, "abort_div", 1'b0);
    n0 = start_q.size();
    idle(40);
    check("abort_no_frame", start_q.size(), n0);
    check_line("abort_idle", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_uart_tx.md
RISCV_UART_TX -- requirements
Module: riscv_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, 32'h8000_0000, base of the 16-byte register window on the core data bus.
REQ-002 Parameter FIFO_DEPTH, 8, TX FIFO entries (power of two, 2..16).
REQ-003 Parameter DIV_RESET, 16'd16, reset value of BAUDDIV.
REQ-004 Port clk_i, input, 1, single clock.
REQ-005 Port reset_i, input, 1, asynchronous active-high reset.
REQ-006 Port daddr_i, input, 32, core data address.
REQ-007 Port dwdata_i, input, 32, core write data.
REQ-008 Port dsize_i, input, 2, access size; ignored, all sizes treated as word.
REQ-009 Port drd_i, input, 1, read strobe.
REQ-010 Port dwr_i, input, 1, write strobe.
REQ-011 Port drdata_o, output, 32, registered read data; 0 when not selected.
REQ-012 Port tx_o, output, 1, serial line, idle high.
REQ-013 Port irq_o, output, 1, high while FIFO empty and shifter idle.

Function
REQ-014 The block SHALL be selected when daddr_i[31:4] == BASE_ADDR[31:4]; the register is chosen by daddr_i[3:2].
REQ-015 Offset 0x0 TXDATA: a write SHALL push dwdata_i[7:0]; a read SHALL return 0.
REQ-016 Offset 0x4 STATUS: a read SHALL return {count[4:0] at [8:4], overflow [3], busy [2], empty [1], full [0]}, upper bits 0.
REQ-017 Writing STATUS with dwdata_i[3]=1 SHALL clear overflow; other STATUS bits SHALL be read-only.
REQ-018 Offset 0x8 BAUDDIV: 16-bit read/write, dwdata_i[15:0]; a read SHALL zero-extend; offset 0xC SHALL read 0 and ignore writes.
REQ-019 drdata_o SHALL be updated on the clock edge after drd_i with a select hit (one-cycle latency) and SHALL be 0 in every other cycle.
REQ-020 A push SHALL be accepted when count < FIFO_DEPTH or a pop occurs in the same cycle; otherwise the byte SHALL be dropped and overflow set.
REQ-021 Simultaneous drd_i and dwr_i SHALL both be performed.
REQ-022 FSM states IDLE, START, DATA, STOP; IDLE→START when FIFO non-empty, popping the head into the shift register in that cycle.
REQ-023 Each of START (tx_o=0), 8 DATA bits (LSB first), STOP (tx_o=1) SHALL last exactly max(BAUDDIV,2) cycles.
REQ-024 STOP→START directly (no idle bit) if FIFO non-empty at STOP end, else STOP→IDLE.
REQ-025 The bit period SHALL be latched at START entry; a BAUDDIV write mid-frame SHALL apply from the next frame.
REQ-026 busy SHALL be 1 in START, DATA and STOP; irq_o = empty & ~busy, registered.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL be a separate counter 0..FIFO_DEPTH.

Reset
REQ-028 Reset SHALL force state IDLE, tx_o=1, drdata_o=0, count=0, pointers=0, overflow=0, BAUDDIV=DIV_RESET, irq_o=1 (first edge after release).
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately (tx_o=1) and discard FIFO contents.

Structure
REQ-030 Register offsets, STATUS bit positions and FSM state encoding SHALL live in shared package riscv_periph_pkg.
REQ-031 The FIFO SHALL be a sub-module riscv_sync_fifo (parameterised width/depth, push/pop/full/empty/count).

Verification
REQ-032 Reset, write TXDATA 0x55 with BAUDDIV=4 -> tx_o low 4 cycles, bits 1,0,1,0,1,0,1,0 for 4 cycles each, high 4 cycles; irq_o returns 1.
REQ-033 Write 9 bytes back-to-back while the shifter is in START of byte 1 -> 8 accepted, STATUS reads full=1 and overflow=1; write STATUS 0x8 -> overflow=0.
REQ-034 Read STATUS at BASE_ADDR+4 -> drdata_o valid exactly one cycle after drd_i, 0 one cycle later; read at 0x9000_0004 -> drdata_o stays 0.
REQ-035 Two bytes queued, BAUDDIV=2 -> second START begins the cycle after the first STOP ends; 40 cycles total tx activity.
REQ-036 Write BAUDDIV=8 during DATA of a frame -> current frame keeps old period, next frame uses 8.
REQ-037 Assert reset_i mid-DATA -> tx_o=1, STATUS reads count=0, empty=1 after release.
